// File: rtl/arb_req_agent.sv
// Requester-side agent for the fixed-priority arbiter. It holds one pending burst per channel
// and drives req. It latches a one-hot grant and then streams the burst on a shared beat bus.
// Optional ARB_REQ_AGENT_CHK_EN adds a sticky err output that flags malformed grants.
module arb_req_agent #(
    parameter int N       = 4,
    parameter int BURST_W = 4,
    parameter int IDX_W   = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         cmd_valid,
    input  logic [N*BURST_W-1:0] cmd_len,
    output logic [N-1:0]         cmd_ready,
    output logic [N-1:0]         req,
    input  logic [N-1:0]         gnt,
    input  logic                 arb_valid,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic [N-1:0]         bus_owner,
    output logic [IDX_W-1:0]     bus_idx,
    output logic                 bus_last,
`ifdef ARB_REQ_AGENT_CHK_EN
    output logic                 err,
`endif
    output logic                 busy
);

    // state | meaning
    // IDLE  | requests visible to arbiter, waiting for a valid grant
    // XFER  | granted burst owns the beat bus, requests masked
    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t                    state_q, state_d;
    logic [N-1:0]              pend_q, pend_d;
    logic [N-1:0][BURST_W-1:0] len_q, len_d;
    logic [N-1:0]              owner_q, owner_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [BURST_W-1:0]        beat_cnt_q, beat_cnt_d;

    logic               gnt_onehot;
    logic               grant_ok;
    logic               last_beat;
    logic               burst_done;
    logic [IDX_W-1:0]   gnt_idx;
    logic [BURST_W-1:0] gnt_len;

    always_comb begin
        gnt_idx = '0;
        gnt_len = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                gnt_idx = IDX_W'(i);
                gnt_len = len_q[i];
            end
        end
    end

    assign gnt_onehot = (gnt != '0) && ((gnt & (gnt - N'(1))) == '0);
    assign grant_ok   = arb_valid && gnt_onehot && ((gnt & pend_q) != '0);
    assign last_beat  = (beat_cnt_q == '0);
    assign burst_done = (state_q == XFER) && bus_ready && last_beat;

    // The owner's own pend bit is still set on its last beat, so a new command
    // on that channel cannot be captured until the following cycle.
    always_comb begin
        pend_d = pend_q;
        len_d  = len_q;
        for (int i = 0; i < N; i++) begin
            if (cmd_valid[i] && !pend_q[i]) begin
                pend_d[i] = 1'b1;
                len_d[i]  = cmd_len[i*BURST_W +: BURST_W];
            end
        end
        if (burst_done) begin
            pend_d = pend_d & ~owner_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            len_q      <= '0;
            owner_q    <= '0;
            idx_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            len_q      <= len_d;
            owner_q    <= owner_d;
            idx_q      <= idx_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        idx_d      = idx_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_ok) begin
                    state_d    = XFER;
                    owner_d    = gnt;
                    idx_d      = gnt_idx;
                    beat_cnt_d = gnt_len;
                end
            end
            XFER: begin
                if (bus_ready) begin
                    if (last_beat) begin
                        state_d = IDLE;
                        owner_d = '0;
                        idx_d   = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q - BURST_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req       = pend_q & {N{state_q == IDLE}};
        cmd_ready = ~pend_q;
        busy      = (state_q == XFER);
        bus_valid = (state_q == XFER);
        bus_owner = (state_q == XFER) ? owner_q : '0;
        bus_idx   = (state_q == XFER) ? idx_q : '0;
        bus_last  = (state_q == XFER) && last_beat;
    end

`ifdef ARB_REQ_AGENT_CHK_EN
    logic err_q, err_d;

    // Any grant while requests are masked is an arbiter protocol violation.
    always_comb begin
        err_d = err_q;
        if (state_q == IDLE && arb_valid && (!gnt_onehot || ((gnt & ~pend_q) != '0))) begin
            err_d = 1'b1;
        end
        if (state_q == XFER && gnt != '0) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
